dns_ip_tx: RTL and testbench

- Transmit counterpart of the DNS receive path.
- Accepts one complete DNS message as a flat byte vector, together with UDP/IP addressing, in a single valid/ready transfer.
- Emits a UDP header transfer, then the payload as an 8-bit AXI-stream, into the UDP transmit path of the Ethernet stack.
- Sits between the DNS responder logic and the UDP TX complex.

---
 rtl/dns_pkg.sv | 20 ++
 rtl/dns_tx_shifter.sv | 38 +++
 rtl/dns_ip_tx.sv | 159 +++++++++++++++
 tb/tb_dns_ip_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dns_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dns_pkg
// Description : Shared constants and state encoding for the DNS RX/TX blocks.
// Revision    : 1.0  initial release
// ============================================================================
package dns_pkg;

  localparam logic [15:0] DNS_PORT      = 16'd53;
  localparam int          UDP_HDR_BYTES = 8;
  localparam int          DNS_MAX_BYTES = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } dns_state_t;

endpackage
`default_nettype wire

// File: rtl/dns_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : dns_tx_shifter
// Description : Wide message register. Parallel load, shift left by one byte,
//               top byte exposed as the current payload byte.
// Revision    : 1.0  initial release
// ============================================================================
module dns_tx_shifter
  import dns_pkg::*;
#(
  parameter int DATA_BYTES = DNS_MAX_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_shift,
  input  logic [DATA_BYTES*8-1:0] i_data,
  output logic [7:0]              o_top
);

  localparam int c_W = DATA_BYTES * 8;

  logic [c_W-1:0] r_sh;

  // Load a whole message, or move the next byte into the top position.
  always_ff @(posedge clk) begin
    if (rst)
      r_sh <= '0;
    else if (i_load)
      r_sh <= i_data;
    else if (i_shift)
      r_sh <= {r_sh[c_W-9:0], 8'h00};
  end

  assign o_top = r_sh[c_W-1 -: 8];

endmodule
`default_nettype wire

// File: rtl/dns_ip_tx.sv
`default_nettype none
// ============================================================================
// Module      : dns_ip_tx
// Description : Takes one flat DNS message plus UDP/IP addressing and sends a
//               UDP header transfer followed by the payload as an 8-bit
//               AXI-stream. Optional statistics counters are enabled with
//               the macro DNS_IP_TX_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module dns_ip_tx
  import dns_pkg::*;
#(
  parameter int DATA_BYTES = DNS_MAX_BYTES,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef DNS_IP_TX_STATS_EN
  output logic [31:0]             tx_frame_count,
  output logic [31:0]             tx_drop_count,
  output logic [31:0]             tx_trunc_count,
`endif
  input  logic                    s_dns_valid,
  output logic                    s_dns_ready,
  input  logic [31:0]             s_udp_src_ip,
  input  logic [31:0]             s_udp_dst_ip,
  input  logic [15:0]             s_udp_source_port,
  input  logic [15:0]             s_udp_dest_port,
  input  logic [CNT_W-1:0]        s_udp_length,
  input  logic [DATA_BYTES*8-1:0] s_dns_pkt,
  output logic                    m_udp_hdr_valid,
  input  logic                    m_udp_hdr_ready,
  output logic [31:0]             m_udp_source_ip,
  output logic [31:0]             m_udp_dest_ip,
  output logic [15:0]             m_udp_source_port,
  output logic [15:0]             m_udp_dest_port,
  output logic [CNT_W-1:0]        m_udp_length,
  output logic [7:0]              m_udp_payload_axis_tdata,
  output logic                    m_udp_payload_axis_tvalid,
  input  logic                    m_udp_payload_axis_tready,
  output logic                    m_udp_payload_axis_tlast,
  output logic                    m_udp_payload_axis_tuser
);

  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(DATA_BYTES);

  dns_state_t       r_state, w_next;
  logic             r_ready;
  logic [CNT_W-1:0] r_len, r_cnt;
  logic             r_trunc;

  logic             w_accept, w_zero, w_trunc_in, w_load;
  logic [CNT_W-1:0] w_len_in;
  logic             w_beat, w_last;

  assign w_accept   = s_dns_valid && r_ready;
  assign w_zero     = (s_udp_length == '0);
  assign w_trunc_in = (s_udp_length > c_MAX);
  assign w_len_in   = w_trunc_in ? c_MAX : s_udp_length;
  assign w_load     = w_accept && !w_zero;
  assign w_beat     = (r_state == ST_PAYLOAD) && m_udp_payload_axis_tready;
  // r_len is never 0 while in PAYLOAD, so the subtraction cannot wrap there.
  assign w_last     = (r_cnt == r_len - CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; zero-length descriptors are swallowed in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_load) w_next = ST_HDR;
      ST_HDR:     if (m_udp_hdr_ready) w_next = ST_PAYLOAD;
      ST_PAYLOAD: if (w_beat && w_last) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Registered ready keeps it low during reset and rises one cycle later.
  always_ff @(posedge clk) begin
    if (rst)
      r_ready <= 1'b0;
    else
      r_ready <= (w_next == ST_IDLE);
  end

  // Capture header fields, effective length and truncation on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_udp_source_ip   <= '0;
      m_udp_dest_ip     <= '0;
      m_udp_source_port <= '0;
      m_udp_dest_port   <= '0;
      m_udp_length      <= '0;
      r_len             <= '0;
      r_trunc           <= 1'b0;
    end else if (w_load) begin
      m_udp_source_ip   <= s_udp_src_ip;
      m_udp_dest_ip     <= s_udp_dst_ip;
      m_udp_source_port <= s_udp_source_port;
      m_udp_dest_port   <= s_udp_dest_port;
      m_udp_length      <= w_len_in + CNT_W'(UDP_HDR_BYTES);
      r_len             <= w_len_in;
      r_trunc           <= w_trunc_in;
    end
  end

  // Payload byte counter.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_load)
      r_cnt <= '0;
    else if (w_beat)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  dns_tx_shifter #(
    .DATA_BYTES (DATA_BYTES)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_beat),
    .i_data  (s_dns_pkt),
    .o_top   (m_udp_payload_axis_tdata)
  );

  assign s_dns_ready               = r_ready;
  assign m_udp_hdr_valid           = (r_state == ST_HDR);
  assign m_udp_payload_axis_tvalid = (r_state == ST_PAYLOAD);
  assign m_udp_payload_axis_tlast  = m_udp_payload_axis_tvalid && w_last;
  assign m_udp_payload_axis_tuser  = m_udp_payload_axis_tlast && r_trunc;

`ifdef DNS_IP_TX_STATS_EN
  // Frame, drop and truncation counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_frame_count <= '0;
      tx_drop_count  <= '0;
      tx_trunc_count <= '0;
    end else begin
      if (w_beat && w_last)
        tx_frame_count <= tx_frame_count + 32'd1;
      if (w_accept && w_zero)
        tx_drop_count <= tx_drop_count + 32'd1;
      if (w_load && w_trunc_in)
        tx_trunc_count <= tx_trunc_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dns_ip_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dns_ip_tx
// Description : Self-checking bench for dns_ip_tx with a byte-queue model.
//               Define DNS_IP_TX_STATS_EN to also check the statistics.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dns_ip_tx;

  localparam int DB = 512;
  localparam int W  = DB * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_dns_valid = 1'b0;
  logic          s_dns_ready;
  logic [31:0]   s_udp_src_ip = '0, s_udp_dst_ip = '0;
  logic [15:0]   s_udp_source_port = '0, s_udp_dest_port = '0, s_udp_length = '0;
  logic [W-1:0]  s_dns_pkt = '0;
  logic          m_udp_hdr_valid;
  logic          m_udp_hdr_ready = 1'b0;
  logic [31:0]   m_udp_source_ip, m_udp_dest_ip;
  logic [15:0]   m_udp_source_port, m_udp_dest_port, m_udp_length;
  logic [7:0]    tdata;
  logic          tvalid, tlast, tuser;
  logic          tready = 1'b0;
`ifdef DNS_IP_TX_STATS_EN
  logic [31:0]   tx_frame_count, tx_drop_count, tx_trunc_count;
  int            e_frames = 0, e_drops = 0, e_truncs = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state for the descriptor in flight
  logic [31:0] e_src, e_dst;
  logic [15:0] e_sp, e_dp;
  int          e_len;
  logic        e_trunc;
  logic [7:0]  exp_q[$];

  dns_ip_tx #(.DATA_BYTES(DB), .CNT_W(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
`ifdef DNS_IP_TX_STATS_EN
    .tx_frame_count            (tx_frame_count),
    .tx_drop_count             (tx_drop_count),
    .tx_trunc_count            (tx_trunc_count),
`endif
    .s_dns_valid               (s_dns_valid),
    .s_dns_ready               (s_dns_ready),
    .s_udp_src_ip              (s_udp_src_ip),
    .s_udp_dst_ip              (s_udp_dst_ip),
    .s_udp_source_port         (s_udp_source_port),
    .s_udp_dest_port           (s_udp_dest_port),
    .s_udp_length              (s_udp_length),
    .s_dns_pkt                 (s_dns_pkt),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_source_ip           (m_udp_source_ip),
    .m_udp_dest_ip             (m_udp_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_payload_axis_tdata  (tdata),
    .m_udp_payload_axis_tvalid (tvalid),
    .m_udp_payload_axis_tready (tready),
    .m_udp_payload_axis_tlast  (tlast),
    .m_udp_payload_axis_tuser  (tuser)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_pkt();
    for (int i = 0; i < W / 32; i++) s_dns_pkt[i*32 +: 32] = $urandom;
  endtask

  task automatic check_hdr();
    check("hdr_src_ip", m_udp_source_ip, e_src);
    check("hdr_dst_ip", m_udp_dest_ip, e_dst);
    check("hdr_sport",  m_udp_source_port, e_sp);
    check("hdr_dport",  m_udp_dest_port, e_dp);
    check("hdr_length", m_udp_length, 64'(e_len + 8));
  endtask

  // Present a descriptor and record what the stream should look like.
  task automatic load_desc(input int len, input logic [15:0] dport);
    rand_pkt();
    s_udp_src_ip      = $urandom;
    s_udp_dst_ip      = $urandom;
    s_udp_source_port = 16'd53;
    s_udp_dest_port   = dport;
    s_udp_length      = 16'(len);
    s_dns_valid       = 1'b1;
    e_src = s_udp_src_ip; e_dst = s_udp_dst_ip;
    e_sp  = s_udp_source_port; e_dp = s_udp_dest_port;
    e_len   = (len > DB) ? DB : len;
    e_trunc = (len > DB);
    exp_q.delete();
    for (int k = 0; k < e_len; k++) exp_q.push_back(s_dns_pkt[W-1-8*k -: 8]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  s_dns_ready, 1);
    check({tag, "_hvalid"}, m_udp_hdr_valid, 0);
    check({tag, "_tvalid"}, tvalid, 0);
  endtask

  // mode 0: tready held 1; mode 1: 1,0,0 repeating; mode 2: random
  task automatic run_frame(input int len, input int hdr_wait, input int mode);
    int   acc, stalls, idx, guard;
    logic tr;
    load_desc(len, 16'($urandom_range(1024, 65535)));
    check("ready_before_accept", s_dns_ready, 1);
    step();
    acc = cyc;
    s_dns_valid = 1'b0;
    rand_pkt();
    s_udp_length = 16'($urandom);
    check("ready_after_accept", s_dns_ready, 0);
    check("hvalid_latency", m_udp_hdr_valid, 1);
    check("tvalid_in_hdr", tvalid, 0);
    check_hdr();
    for (int w = 0; w < hdr_wait; w++) begin
      m_udp_hdr_ready = 1'b0;
      tready = $urandom_range(0, 1);
      step();
      check("hvalid_hold", m_udp_hdr_valid, 1);
      check("tvalid_before_hdr", tvalid, 0);
      check_hdr();
    end
    m_udp_hdr_ready = 1'b1;
    step();
    stalls = 0; idx = 0; guard = 0;
    while (idx < e_len && guard < 8 * e_len + 16) begin
      check("pl_tvalid", tvalid, 1);
      check("pl_hvalid", m_udp_hdr_valid, 0);
      check("pl_ready",  s_dns_ready, 0);
      check("pl_tdata",  tdata, exp_q[idx]);
      check("pl_tlast",  tlast, (idx == e_len - 1));
      check("pl_tuser",  tuser, (idx == e_len - 1) && e_trunc);
      case (mode)
        0:       tr = 1'b1;
        1:       tr = (guard % 3 == 0);
        default: tr = 1'($urandom_range(0, 1));
      endcase
      tready          = tr;
      m_udp_hdr_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
      if (tr) idx++; else stalls++;
    end
    tready = 1'b0;
    m_udp_hdr_ready = 1'b0;
    check("payload_complete", idx, e_len);
    check_idle_outputs("frame_end");
    check("frame_cycles", cyc - acc, 1 + hdr_wait + e_len + stalls);
`ifdef DNS_IP_TX_STATS_EN
    e_frames++;
    if (e_trunc) e_truncs++;
`endif
  endtask

  task automatic run_zero();
    load_desc(0, 16'd1234);
    step();
    s_dns_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_udp_hdr_ready = 1'($urandom_range(0, 1));
      tready = 1'($urandom_range(0, 1));
      check_idle_outputs("zero_len");
      step();
    end
    m_udp_hdr_ready = 1'b0;
    tready = 1'b0;
`ifdef DNS_IP_TX_STATS_EN
    e_drops++;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  s_dns_ready, 0);
    check({tag, "_hvalid"}, m_udp_hdr_valid, 0);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tlast"},  tlast, 0);
    check({tag, "_tuser"},  tuser, 0);
    check({tag, "_tdata"},  tdata, 0);
    check({tag, "_len"},    m_udp_length, 0);
    check({tag, "_ip"},     {m_udp_source_ip, m_udp_dest_ip}, 0);
    check({tag, "_port"},   {m_udp_source_port, m_udp_dest_port}, 0);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("ready_after_reset", s_dns_ready, 1);

    // basic 12-byte frame, continuous handshakes
    run_frame(12, 0, 0);
    // zero-length descriptor dropped
    run_zero();
    // oversize frame truncated to capacity
    run_frame(600, 0, 0);
    // header backpressure and stuttering payload
    run_frame(4, 5, 1);
    // exactly capacity: no truncation flag
    run_frame(DB, 0, 2);

    // reset in the middle of a 10-byte frame, after byte 3
    load_desc(10, 16'd4000);
    step();
    s_dns_valid = 1'b0;
    m_udp_hdr_ready = 1'b1;
    step();
    m_udp_hdr_ready = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_tdata", tdata, exp_q[i]);
      step();
    end
    tready = 1'b0;
    rst = 1'b1;
    step();
    check_all_zero("abort");
`ifdef DNS_IP_TX_STATS_EN
    e_frames = 0; e_drops = 0; e_truncs = 0;
`endif
    rst = 1'b0;
    step();
    check_idle_outputs("after_abort");
    run_frame(2, 0, 0);

    // randomized traffic
    for (int n = 0; n < 8; n++) begin
      if (n == 3) run_zero();
      else run_frame($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    run_frame($urandom_range(DB + 1, 1000), 1, 2);

`ifdef DNS_IP_TX_STATS_EN
    check("stat_frames", tx_frame_count, e_frames);
    check("stat_drops",  tx_drop_count,  e_drops);
    check("stat_truncs", tx_trunc_count, e_truncs);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
